// File: rtl/nios_button_pio.sv
// Avalon-MM input PIO: synchronised, optionally debounced button lines with sticky edge capture
// and maskable level irq. Define NIOS_BUTTON_PIO_DEBOUNCE_EN to build the debounce counters.
module nios_button_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] meta_q, sync_q;
    logic [WIDTH-1:0] stable, stable_prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_evt;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= in_port;
            sync_q <= meta_q;
        end
    end

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           stable_q, stable_d;

    // Any cycle where sync agrees with stable restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
`else
    // Without debounce the synchroniser output is the accepted state.
    assign stable = sync_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_prev_q <= '0;
        end else begin
            stable_prev_q <= stable;
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_evt = stable & ~stable_prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_evt = ~stable & stable_prev_q;
        end else begin
            edge_evt = stable ^ stable_prev_q;
        end
    end

    // A new event outranks a write-1-clear landing on the same bit.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_evt;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

endmodule
